cache_replacer: RTL and testbench

Parametrised per-set replacement controller for the set-associative data cache. Each cycle it accepts one lookup (set index, tag, and the tag/valid/dirty state of that set's ways from the external tag array), returns a registered hit/victim decision one cycle later, and keeps per-set replacement state. Replacement policy is selectable at elaboration: true LRU, FIFO, or pseudo-random. It replaces the fixed 4-way, single-set, hit-only update controller.

---
 rtl/cache_replacer.sv | 115 +++++++++++
 tb/tb_cache_replacer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cache_replacer.sv
// cache_replacer: per-set hit detection and LRU/FIFO/random victim selection
module cache_replacer #(
  parameter int TAG_WIDTH = 20,
  parameter int WAYS = 4,
  parameter int SETS = 16,
  parameter int POLICY = 0,
  localparam int WB = $clog2(WAYS),
  localparam int SB = $clog2(SETS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SB-1:0]             req_set,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  input  logic [WAYS*TAG_WIDTH-1:0] way_tag,
  input  logic [WAYS-1:0]           way_valid,
  input  logic [WAYS-1:0]           way_dirty,
  input  logic                      fill_valid,
  input  logic [SB-1:0]             fill_set,
  input  logic [WB-1:0]             fill_way,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [WB-1:0]             resp_way,
  output logic                      resp_dirty,
  output logic [TAG_WIDTH-1:0]      resp_victim_tag,
  output logic                      resp_multihit
);
  logic [WAYS-1:0] match;
  logic [TAG_WIDTH-1:0] tags [WAYS];
  logic [WB-1:0] hit_way, inv_way, pol_way, sel_way;
  logic hit, multi, fire;
  assign req_ready = !fill_valid;
  assign fire = req_valid && req_ready;
  assign hit = |match;
  assign multi = (match & (match - WAYS'(1))) != '0;
  assign sel_way = hit ? hit_way : !(&way_valid) ? inv_way : pol_way;
  // tag compare; descending scan leaves the lowest matching / invalid index
  always_comb begin
    match = '0;
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      tags[w] = way_tag[w*TAG_WIDTH +: TAG_WIDTH];
      match[w] = way_valid[w] && tags[w] == req_tag;
      hit_way = match[w] ? WB'(w) : hit_way;
      inv_way = !way_valid[w] ? WB'(w) : inv_way;
    end
  end
  if (POLICY == 0) begin : g_lru
    logic [WB-1:0] age [SETS][WAYS];
    logic upd;
    logic [SB-1:0] t_set;
    logic [WB-1:0] t_way;
    assign upd = fill_valid || (req_valid && hit);
    assign t_set = fill_valid ? fill_set : req_set;
    assign t_way = fill_valid ? fill_way : hit_way;
    // oldest way of the requested set
    always_comb begin
      pol_way = '0;
      for (int w = 0; w < WAYS; w++)
        pol_way = age[req_set][w] == WB'(WAYS - 1) ? WB'(w) : pol_way;
    end
    // touch: younger ways age by one, touched way becomes youngest
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age[s][w] <= WB'(WAYS - 1 - w);
      end else if (upd) begin
        for (int w = 0; w < WAYS; w++)
          age[t_set][w] <= WB'(w) == t_way ? '0 :
                           age[t_set][w] + WB'(age[t_set][w] < age[t_set][t_way]);
      end
    end
  end else if (POLICY == 1) begin : g_fifo
    logic [WB-1:0] ptr [SETS];
    assign pol_way = ptr[req_set];
    // pointer advances only when the way it names gets filled
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++)
          ptr[s] <= '0;
      end else if (fill_valid && fill_way == ptr[fill_set]) begin
        ptr[fill_set] <= ptr[fill_set] + WB'(1);
      end
    end
  end else begin : g_rand
    logic [15:0] lfsr;
    assign pol_way = lfsr[WB-1:0];
    // free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk)
      lfsr <= reset ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  // registered response; payload holds while no request fires
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_hit <= 1'b0;
      resp_way <= '0;
      resp_dirty <= 1'b0;
      resp_victim_tag <= '0;
      resp_multihit <= 1'b0;
    end else begin
      resp_valid <= fire;
      if (fire) begin
        resp_hit <= hit;
        resp_way <= sel_way;
        resp_dirty <= way_dirty[sel_way];
        resp_victim_tag <= tags[sel_way];
        resp_multihit <= multi;
      end
    end
  end
endmodule

// File: tb/tb_cache_replacer.sv
// tb_cache_replacer: directed vectors for LRU, FIFO and RANDOM instances sharing one stimulus
module tb_cache_replacer;
  localparam int TW = 20, W = 4, S = 16;
  localparam logic [W*TW-1:0] TG = {20'h13, 20'h12, 20'h11, 20'h10};
  localparam logic [W*TW-1:0] MH = {20'h55, 20'h12, 20'h55, 20'h10};
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, fill_valid = 1'b0;
  logic [3:0] req_set = 4'd0, fill_set = 4'd0;
  logic [1:0] fill_way = 2'd0;
  logic [TW-1:0] req_tag = '0;
  logic [W*TW-1:0] way_tag = '0;
  logic [W-1:0] way_valid = '0, way_dirty = '0;
  logic rdy [3], rv [3], rh [3], rd [3], rm [3];
  logic [1:0] rw [3];
  logic [TW-1:0] rt [3];
  logic [15:0] m_lfsr;
  int checks = 0, errors = 0;
  typedef struct {
    string name;
    int dut;
    logic fill;
    logic [3:0] fset;
    logic [1:0] fway;
    logic req;
    logic [3:0] set;
    logic [TW-1:0] tag;
    logic [W*TW-1:0] tags;
    logic [W-1:0] vld, drt;
    logic rdy, rv, hit;
    logic [1:0] way;
    logic dirty, mh;
    logic [TW-1:0] vtag;
  } vec_t;
  vec_t v [$];
  always #5 clk = ~clk;
  always @(posedge clk)
    m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  for (genvar p = 0; p < 3; p++) begin : g_dut
    cache_replacer #(.TAG_WIDTH(TW), .WAYS(W), .SETS(S), .POLICY(p)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[p]),
      .req_set(req_set), .req_tag(req_tag), .way_tag(way_tag),
      .way_valid(way_valid), .way_dirty(way_dirty), .fill_valid(fill_valid),
      .fill_set(fill_set), .fill_way(fill_way), .resp_valid(rv[p]), .resp_hit(rh[p]),
      .resp_way(rw[p]), .resp_dirty(rd[p]), .resp_victim_tag(rt[p]), .resp_multihit(rm[p]));
  end
  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, p, act, exp);
    end
  endtask
  function automatic vec_t mk(string n, int d, logic f, logic [3:0] fs, logic [1:0] fw,
                              logic r, logic [3:0] s, logic [TW-1:0] t, logic [W*TW-1:0] tg,
                              logic [3:0] vl, logic [3:0] dr, logic e_rdy, logic e_rv, logic e_hit,
                              logic [1:0] e_way, logic e_d, logic e_mh, logic [TW-1:0] e_t);
    vec_t x;
    x.name = n; x.dut = d; x.fill = f; x.fset = fs; x.fway = fw;
    x.req = r; x.set = s; x.tag = t; x.tags = tg; x.vld = vl; x.drt = dr;
    x.rdy = e_rdy; x.rv = e_rv; x.hit = e_hit; x.way = e_way; x.dirty = e_d; x.mh = e_mh; x.vtag = e_t;
    return x;
  endfunction
  task automatic apply(input vec_t x);
    fill_valid = x.fill; fill_set = x.fset; fill_way = x.fway;
    req_valid = x.req; req_set = x.set; req_tag = x.tag;
    way_tag = x.tags; way_valid = x.vld; way_dirty = x.drt;
    #1;
    for (int p = 0; p < 3; p++)
      if (x.dut == 3 || x.dut == p) chk({x.name, " ready"}, p, 32'(rdy[p]), 32'(x.rdy));
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 3; p++)
      if (x.dut == 3 || x.dut == p) begin
        chk({x.name, " valid"}, p, 32'(rv[p]), 32'(x.rv));
        if (x.rv) begin
          chk({x.name, " hit"}, p, 32'(rh[p]), 32'(x.hit));
          chk({x.name, " way"}, p, 32'(rw[p]), 32'(x.way));
          chk({x.name, " dirty"}, p, 32'(rd[p]), 32'(x.dirty));
          chk({x.name, " multihit"}, p, 32'(rm[p]), 32'(x.mh));
          chk({x.name, " vtag"}, p, 32'(rt[p]), 32'(x.vtag));
        end
      end
    fill_valid = 1'b0;
    req_valid = 1'b0;
  endtask
  initial begin
    v.push_back(mk("lru_miss_set3", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd3, 20'h99, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'h10));
    v.push_back(mk("lru_hit0", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 20'h10, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 20'h10));
    v.push_back(mk("lru_hit1", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 20'h11, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 20'h11));
    v.push_back(mk("lru_hit2", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 20'h12, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 20'h12));
    v.push_back(mk("lru_victim3", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 20'h99, TG, 4'hF, 4'h8, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 20'h13));
    v.push_back(mk("lru_hit3", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 20'h13, TG, 4'hF, 4'h8, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 20'h13));
    v.push_back(mk("lru_victim0", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 20'h99, TG, 4'hF, 4'h8, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'h10));
    v.push_back(mk("inv_victim", 3, 1'b0, 4'd0, 2'd0, 1'b1, 4'd7, 20'h99, TG, 4'b1011, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 20'h12));
    v.push_back(mk("multihit", 3, 1'b0, 4'd0, 2'd0, 1'b1, 4'd7, 20'h55, MH, 4'hF, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 20'h55));
    v.push_back(mk("pair_one_valid", 3, 1'b0, 4'd0, 2'd0, 1'b1, 4'd7, 20'h55, MH, 4'b1101, 4'h0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 20'h55));
    v.push_back(mk("fifo_fill0", 1, 1'b1, 4'd0, 2'd0, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_fill1", 1, 1'b1, 4'd0, 2'd1, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_fill2", 1, 1'b1, 4'd0, 2'd2, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_fill3", 1, 1'b1, 4'd0, 2'd3, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_victim0", 1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'h10));
    v.push_back(mk("fifo_hit2", 1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 20'h12, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 20'h12));
    v.push_back(mk("fifo_fill_other", 1, 1'b1, 4'd0, 2'd2, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_still0", 1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 20'h99, TG, 4'hF, 4'h1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 20'h10));
    v.push_back(mk("fifo_fill_ptr", 1, 1'b1, 4'd0, 2'd0, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_victim1", 1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 20'h11));
    v.push_back(mk("fifo_fill_set1", 1, 1'b1, 4'd1, 2'd1, 1'b0, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 20'h0));
    v.push_back(mk("fifo_victim1b", 1, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 20'h99, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 20'h11));
    repeat (2) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      chk("reset valid", p, 32'(rv[p]), 32'd0);
      chk("reset hit", p, 32'(rh[p]), 32'd0);
      chk("reset way", p, 32'(rw[p]), 32'd0);
      chk("reset dirty", p, 32'(rd[p]), 32'd0);
      chk("reset multihit", p, 32'(rm[p]), 32'd0);
      chk("reset vtag", p, 32'(rt[p]), 32'd0);
      chk("reset ready", p, 32'(rdy[p]), 32'd1);
    end
    reset = 1'b0;
    foreach (v[i]) apply(v[i]);
    @(posedge clk);
    @(negedge clk);
    chk("idle valid", 1, 32'(rv[1]), 32'd0);
    chk("idle way hold", 1, 32'(rw[1]), 32'd1);
    chk("idle vtag hold", 1, 32'(rt[1]), 32'h11);
    fill_valid = 1'b1; fill_set = 4'd9; fill_way = 2'd0;
    req_valid = 1'b1; req_set = 4'd9; req_tag = 20'h99; way_tag = TG; way_valid = 4'hF; way_dirty = 4'h0;
    #1;
    chk("collide ready low", 0, 32'(rdy[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("collide no resp", 0, 32'(rv[0]), 32'd0);
    fill_valid = 1'b0;
    #1;
    chk("collide ready high", 0, 32'(rdy[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post fill valid", 0, 32'(rv[0]), 32'd1);
    chk("post fill hit", 0, 32'(rh[0]), 32'd0);
    chk("post fill victim", 0, 32'(rw[0]), 32'd1);
    chk("post fill vtag", 0, 32'(rt[0]), 32'h11);
    req_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      chk("midreset valid", p, 32'(rv[p]), 32'd0);
      chk("midreset way", p, 32'(rw[p]), 32'd0);
      chk("midreset vtag", p, 32'(rt[p]), 32'd0);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    apply(mk("lru_after_reset", 0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd9, 20'h99, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 20'h10));
    for (int i = 0; i < 10; i++) begin
      logic [1:0] e;
      e = m_lfsr[1:0];
      apply(mk("rand_victim", 2, 1'b0, 4'd0, 2'd0, 1'b1, 4'd12, 20'h99, TG, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, e, 1'b0, 1'b0, 20'h10 + 20'(e)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
